timeout_static_priority_dispatcher: RTL and testbench
=====================================================

TIMEOUT_STATIC_PRIORITY_DISPATCHER -- requirements
Module: timeout_static_priority_dispatcher

Interface
REQ-001 Parameter SIZE, default 4: number of downstream channels; SHALL be >= 2.
REQ-002 Parameter WIDTH, default 8: payload width in bits.
REQ-003 Parameter TIMEOUT, default 8: waiting transfers after which a ready channel preempts static priority; SHALL be >= 1.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 upstream_valid  input  1  upstream payload available.
REQ-007 upstream_data  input  WIDTH  upstream payload.
REQ-008 upstream_ready  output  1  dispatcher accepts the payload this cycle.
REQ-009 downstream_valid  output  SIZE  one-hot, or zero; payload offered to the selected channel.
REQ-010 downstream_data  output  WIDTH  buffered payload, broadcast to all channels.
REQ-011 downstream_ready  input  SIZE  per-channel sink ready.

Function
REQ-012 Single-entry buffer (buffer_valid, buffer_data); upstream transfer = upstream_valid & upstream_ready; captures upstream_data, sets buffer_valid.
REQ-013 upstream_ready SHALL equal !buffer_valid | downstream transfer in the same cycle (full throughput with back-to-back traffic).
REQ-014 Latency: payload accepted at edge N SHALL be offered on downstream_valid in cycle N+1 at the earliest.
REQ-015 Per-channel countdown, width clog2(TIMEOUT+1); channel i is timed out when countdown[i] == 0.
REQ-016 Selection, combinational: candidates = downstream_ready; if any candidate is timed out, lowest-index timed-out candidate; else lowest-index candidate; none if downstream_ready == 0.
REQ-017 downstream_valid SHALL equal buffer_valid ? one-hot(selection) : 0; downstream_valid depends combinationally on downstream_ready; sinks SHALL NOT make ready depend on valid.
REQ-018 Downstream transfer = buffer_valid & |downstream_ready; payload goes to exactly one channel; buffer clears unless refilled in the same cycle.
REQ-019 On a downstream transfer, selected channel countdown SHALL reload to TIMEOUT.
REQ-020 On a downstream transfer, every other ready channel with countdown > 0 SHALL decrement by 1.
REQ-021 Countdown SHALL hold when the channel is not ready, when buffer_valid = 0, or when it is already 0 (saturate, no wrap).
REQ-022 Simultaneous upstream and downstream transfer: buffer SHALL hold the new payload, buffer_valid stays 1, no bubble.
REQ-023 downstream_data SHALL hold stable while buffer_valid = 1 and no transfer occurs.
REQ-024 Several channels timed out at once: lowest index wins; the others keep countdown 0 and win on subsequent transfers in index order.
REQ-025 With channel 0 and channel k constantly ready, pattern SHALL be TIMEOUT transfers to channel 0, then 1 to channel k, period TIMEOUT+1.

Reset
REQ-026 reset = 1 at an edge: buffer_valid = 0, all countdowns = TIMEOUT; any buffered payload is discarded.
REQ-027 During and after reset: downstream_valid = 0, upstream_ready = 1; buffer_data value is don't-care.
REQ-028 Reset asserted mid-operation overrides any same-cycle transfer and SHALL take priority over all other updates.

Verification
REQ-029 Always: $countones(downstream_valid) <= 1; downstream_valid implies downstream_ready; buffer_valid & |downstream_ready implies exactly one valid bit.
REQ-030 Single ready channel: ready = 4'b0100, 20 back-to-back payloads 0x00..0x13 -> all delivered in order on channel 2, one per cycle after 1-cycle latency, upstream_ready constantly 1.
REQ-031 Static priority: for each ready pattern 1..15 with one payload and fresh reset -> valid equals lowest set bit of ready.
REQ-032 Timeout preemption: ready = 4'b0001 | (1<<k), k = 1..3, 45 continuous payloads -> transfers 1-8 to channel 0, transfer 9 to channel k, pattern repeats.
REQ-033 Backpressure: ready = 0 for 10 cycles with a buffered payload 0xA5 -> upstream_ready = 0, data held at 0xA5, countdowns unchanged; ready = 4'b1000 -> 0xA5 delivered to channel 3.
REQ-034 Reset mid-operation: reset while buffer holds 0x3C and countdowns < TIMEOUT -> next cycle downstream_valid = 0, upstream_ready = 1, 0x3C never delivered, all-ready traffic restarts with channel 0 winning 8 transfers.

Source files
------------

// File: rtl/timeout_static_priority_dispatcher.sv
// Single-entry dispatcher that steers each payload to one ready sink.
// Static lowest-index priority applies unless a ready sink's countdown has expired.
module timeout_static_priority_dispatcher #(
   parameter int SIZE    = 4,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             upstream_valid,
   input  logic [WIDTH-1:0] upstream_data,
   output logic             upstream_ready,
   output logic [SIZE-1:0]  downstream_valid,
   output logic [WIDTH-1:0] downstream_data,
   input  logic [SIZE-1:0]  downstream_ready
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT);

   logic             r_bufferValid;
   logic [WIDTH-1:0] r_bufferData;
   logic [CW-1:0]    r_countdown [SIZE];

   logic [SIZE-1:0]  w_timedOut;
   logic [SIZE-1:0]  w_select;
   logic             w_found;
   logic             w_upXfer;
   logic             w_downXfer;

   // Expired ready channels outrank everyone; otherwise plain lowest-index priority.
   always_comb begin
      w_timedOut = '0;
      w_select   = '0;
      w_found    = 1'b0;
      for (int i = 0; i < SIZE; i++) begin
         w_timedOut[i] = downstream_ready[i] && (r_countdown[i] == '0);
      end
      for (int i = 0; i < SIZE; i++) begin
         if (!w_found && w_timedOut[i]) begin
            w_select[i] = 1'b1;
            w_found     = 1'b1;
         end
      end
      for (int i = 0; i < SIZE; i++) begin
         if (!w_found && downstream_ready[i]) begin
            w_select[i] = 1'b1;
            w_found     = 1'b1;
         end
      end
   end

   assign w_downXfer       = r_bufferValid && (|downstream_ready);
   assign upstream_ready   = !r_bufferValid || w_downXfer;
   assign w_upXfer         = upstream_valid && upstream_ready;
   assign downstream_valid = r_bufferValid ? w_select : '0;
   assign downstream_data  = r_bufferData;

   // Reset outranks any transfer; a refill in the same cycle as a drain keeps the buffer full.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_bufferValid <= 1'b0;
         r_bufferData  <= '0;
         for (int i = 0; i < SIZE; i++) begin
            r_countdown[i] <= RELOAD;
         end
      end else begin
         if (w_upXfer) begin
            r_bufferValid <= 1'b1;
            r_bufferData  <= upstream_data;
         end else if (w_downXfer) begin
            r_bufferValid <= 1'b0;
         end
         if (w_downXfer) begin
            for (int i = 0; i < SIZE; i++) begin
               if (w_select[i]) begin
                  r_countdown[i] <= RELOAD;
               end else if (downstream_ready[i] && (r_countdown[i] != '0)) begin
                  r_countdown[i] <= r_countdown[i] - CW'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_timeout_static_priority_dispatcher.sv
// Bench for the timeout dispatcher: priority table, back-to-back streaming,
// timeout preemption, backpressure and mid-stream reset, checked via a scoreboard.
module tb_timeout_static_priority_dispatcher;

   logic       clock = 1'b0;
   logic       reset;
   logic       upstream_valid;
   logic [7:0] upstream_data;
   logic       upstream_ready;
   logic [3:0] downstream_valid;
   logic [7:0] downstream_data;
   logic [3:0] downstream_ready;

   typedef struct {
      logic [3:0] ready;
      logic [3:0] expValid;
   } vec_t;

   typedef struct {
      logic [3:0] valid;
      logic [7:0] data;
   } exp_t;

   vec_t prioTable [15];
   exp_t expQueue [$];
   int   vecCount  = 0;
   int   missCount = 0;

   timeout_static_priority_dispatcher #(.SIZE(4), .WIDTH(8), .TIMEOUT(8)) dut (
      .clock            (clock),
      .reset            (reset),
      .upstream_valid   (upstream_valid),
      .upstream_data    (upstream_data),
      .upstream_ready   (upstream_ready),
      .downstream_valid (downstream_valid),
      .downstream_data  (downstream_data),
      .downstream_ready (downstream_ready)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      vecCount++;
      if (actual !== required) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, required, $time);
      end
   endtask

   // Every offered payload is a transfer, so each nonzero valid pops one expectation.
   always @(negedge clock) begin
      if (downstream_valid !== 4'b0000) begin
         exp_t e;
         checkOutput("onehot", 32'($countones(downstream_valid) <= 1), 32'd1);
         checkOutput("validNotReady", 32'(downstream_valid & ~downstream_ready), 32'd0);
         if (expQueue.size() == 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL unexpected: got valid %0h data %0h, expected nothing", downstream_valid, downstream_data);
         end else begin
            e = expQueue.pop_front();
            checkOutput("channel", 32'(downstream_valid), 32'(e.valid));
            checkOutput("data", 32'(downstream_data), 32'(e.data));
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] data, input logic [3:0] expValid, output int waits);
      exp_t e;
      waits = 0;
      upstream_valid = 1'b1;
      upstream_data  = data;
      for (int c = 0; c < 50; c++) begin
         @(negedge clock);
         if (upstream_ready) begin
            e.valid = expValid;
            e.data  = data;
            expQueue.push_back(e);
            @(posedge clock);
            #1;
            return;
         end
         waits++;
         @(posedge clock);
         #1;
      end
      checkOutput("acceptTimeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      upstream_valid = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (expQueue.size() == 0) break;
         @(posedge clock);
         #1;
      end
      checkOutput("drain", 32'(expQueue.size()), 32'd0);
   endtask

   task automatic doReset();
      upstream_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      #1;
      @(negedge clock);
      checkOutput("resetValid", 32'(downstream_valid), 32'd0);
      checkOutput("resetReady", 32'(upstream_ready), 32'd1);
      @(posedge clock);
      #1;
      reset = 1'b0;
      expQueue.delete();
   endtask

   initial begin
      int waits;
      prioTable[0]  = '{4'b0001, 4'b0001};
      prioTable[1]  = '{4'b0010, 4'b0010};
      prioTable[2]  = '{4'b0011, 4'b0001};
      prioTable[3]  = '{4'b0100, 4'b0100};
      prioTable[4]  = '{4'b0101, 4'b0001};
      prioTable[5]  = '{4'b0110, 4'b0010};
      prioTable[6]  = '{4'b0111, 4'b0001};
      prioTable[7]  = '{4'b1000, 4'b1000};
      prioTable[8]  = '{4'b1001, 4'b0001};
      prioTable[9]  = '{4'b1010, 4'b0010};
      prioTable[10] = '{4'b1011, 4'b0001};
      prioTable[11] = '{4'b1100, 4'b0100};
      prioTable[12] = '{4'b1101, 4'b0001};
      prioTable[13] = '{4'b1110, 4'b0010};
      prioTable[14] = '{4'b1111, 4'b0001};

      reset            = 1'b1;
      upstream_valid   = 1'b0;
      upstream_data    = 8'h00;
      downstream_ready = 4'b0000;
      doReset();

      // Static priority with fresh countdowns.
      for (int i = 0; i < 15; i++) begin
         doReset();
         downstream_ready = prioTable[i].ready;
         applyStimulus(8'(8'h40 + i), prioTable[i].expValid, waits);
         drain();
      end

      // Single ready channel, back-to-back stream with no bubbles.
      doReset();
      downstream_ready = 4'b0100;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(8'(i), 4'b0100, waits);
         checkOutput("streamStall", 32'(waits), 32'd0);
      end
      drain();

      // Timeout preemption: every ninth transfer goes to channel k.
      for (int k = 1; k < 4; k++) begin
         doReset();
         downstream_ready = 4'b0001 | 4'(1 << k);
         for (int j = 1; j <= 45; j++) begin
            applyStimulus(8'(j), (j % 9 == 0) ? 4'(1 << k) : 4'b0001, waits);
         end
         drain();
      end

      // Backpressure: payload held while no sink is ready.
      doReset();
      downstream_ready = 4'b0000;
      applyStimulus(8'hA5, 4'b1000, waits);
      upstream_valid = 1'b1;
      upstream_data  = 8'h5A;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         checkOutput("holdReady", 32'(upstream_ready), 32'd0);
         checkOutput("holdData", 32'(downstream_data), 32'hA5);
         checkOutput("holdValid", 32'(downstream_valid), 32'd0);
         @(posedge clock);
         #1;
      end
      upstream_valid   = 1'b0;
      downstream_ready = 4'b1000;
      drain();

      // Reset with a payload buffered and countdowns partly consumed.
      doReset();
      downstream_ready = 4'b1111;
      for (int j = 0; j < 4; j++) begin
         applyStimulus(8'(8'h10 + j), 4'b0001, waits);
      end
      drain();
      downstream_ready = 4'b0000;
      applyStimulus(8'h3C, 4'b0001, waits);
      upstream_valid = 1'b0;
      @(posedge clock);
      #1;
      doReset();
      checkOutput("postResetValid", 32'(downstream_valid), 32'd0);
      checkOutput("postResetReady", 32'(upstream_ready), 32'd1);
      downstream_ready = 4'b1111;
      for (int j = 1; j <= 9; j++) begin
         applyStimulus(8'(8'h80 + j), (j == 9) ? 4'b0010 : 4'b0001, waits);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
